// File: rtl/aud_recorder_multi.sv
// I2S record-path capture engine: left, right, stereo-interleaved or mono-mix words out to SRAM.
// Write strobe lands one bclk after a word's LSB; no backpressure, the SRAM port takes every o_valid.
module aud_recorder_multi #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 20,
  parameter int MAX_WORDS = 1000000
) (
  input  logic              i_bclk,
  input  logic              i_rst,
  input  logic              i_lrc,
  input  logic              i_data,
  input  logic [1:0]        i_mode,
  input  logic              i_start,
  input  logic              i_pause,
  input  logic              i_stop,
  output logic [ADDR_W-1:0] o_address,
  output logic [DATA_W-1:0] o_data,
  output logic              o_valid,
  output logic              o_busy,
  output logic              o_full,
  output logic [ADDR_W:0]   o_len
);

  localparam int              CNT_W    = $clog2(DATA_W);
  localparam logic [ADDR_W:0] MAX_L    = (ADDR_W+1)'(MAX_WORDS);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W-1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SYNC,
    S_CAPTURE,
    S_WAIT,
    S_PAUSE
  } state_t;

  state_t state_q, state_d;

  logic              lrc_d;
  logic [CNT_W-1:0]  bit_cnt;
  logic [DATA_W-2:0] shift_q;
  logic [1:0]        mode_q;
  logic              slot_q;
  logic [DATA_W-1:0] mix_l_q;
  logic              pend_q;
  logic [DATA_W-1:0] pend_dat_q;

  logic                     boundary;
  logic                     sync_tgt;
  logic                     wait_tgt;
  logic                     enter_cap;
  logic                     cap_last;
  logic                     cap_wr;
  logic                     cap_mix_l;
  logic                     hit_full;
  logic                     room_fail;
  logic                     full_set;
  logic                     clr_rec;
  logic                     start_cap;
  logic [DATA_W-1:0]        word;
  logic signed [DATA_W:0]   mix_sum;
  logic [ADDR_W:0]          len_next;

  assign boundary = (i_lrc != lrc_d);
  assign sync_tgt = (mode_q == 2'd1);
  assign word     = {shift_q, i_data};
  assign mix_sum  = $signed({mix_l_q[DATA_W-1], mix_l_q}) + $signed({word[DATA_W-1], word});
  assign len_next = o_len + (ADDR_W+1)'(pend_q);

  // Stereo and mix alternate slots; single-channel modes always return to their own slot.
  always_comb begin
    wait_tgt = ~slot_q;
    if (mode_q == 2'd0) wait_tgt = 1'b0;
    else if (mode_q == 2'd1) wait_tgt = 1'b1;
  end

  assign enter_cap = boundary && (((state_q == S_SYNC) && (i_lrc == sync_tgt)) ||
                                  ((state_q == S_WAIT) && (i_lrc == wait_tgt)));
  assign cap_last  = (state_q == S_CAPTURE) && (bit_cnt == LAST_BIT);
  assign cap_wr    = cap_last && ((mode_q != 2'd3) || slot_q);
  assign cap_mix_l = cap_last && (mode_q == 2'd3) && !slot_q;
  assign hit_full  = pend_q && (len_next == MAX_L);
  // A stereo frame must fit whole, otherwise the L word would be orphaned.
  assign room_fail = enter_cap && (mode_q == 2'd2) && !i_lrc &&
                     ((MAX_L - len_next) < (ADDR_W+1)'(2));

  always_comb begin
    state_d   = state_q;
    clr_rec   = 1'b0;
    start_cap = 1'b0;
    full_set  = hit_full;
    if (i_stop) begin
      state_d = S_IDLE;
    end else if ((state_q != S_IDLE) && (hit_full || room_fail)) begin
      state_d  = S_IDLE;
      full_set = 1'b1;
    end else if (i_pause && ((state_q == S_SYNC) || (state_q == S_CAPTURE) ||
                             (state_q == S_WAIT))) begin
      state_d = S_PAUSE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (i_start) begin
            state_d = S_SYNC;
            clr_rec = 1'b1;
          end
        end
        S_SYNC, S_WAIT: begin
          if (enter_cap) begin
            state_d   = S_CAPTURE;
            start_cap = 1'b1;
          end
        end
        S_CAPTURE: begin
          if (cap_last) state_d = S_WAIT;
        end
        S_PAUSE: begin
          if (i_start) state_d = S_SYNC;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_bclk) begin
    if (i_rst) begin
      state_q    <= S_IDLE;
      lrc_d      <= 1'b0;
      bit_cnt    <= '0;
      shift_q    <= '0;
      mode_q     <= 2'd0;
      slot_q     <= 1'b0;
      mix_l_q    <= '0;
      pend_q     <= 1'b0;
      pend_dat_q <= '0;
      o_address  <= '0;
      o_data     <= '0;
      o_valid    <= 1'b0;
      o_busy     <= 1'b0;
      o_full     <= 1'b0;
      o_len      <= '0;
    end else begin
      state_q <= state_d;
      lrc_d   <= i_lrc;
      o_busy  <= (state_d != S_IDLE);
      o_valid <= pend_q;
      pend_q  <= cap_wr;
      if (cap_wr)    pend_dat_q <= (mode_q == 2'd3) ? DATA_W'(mix_sum >>> 1) : word;
      if (cap_mix_l) mix_l_q    <= word;
      // A completed word is written even if stop or pause arrived with its LSB.
      if (pend_q) begin
        o_data    <= pend_dat_q;
        o_address <= o_len[ADDR_W-1:0];
        o_len     <= len_next;
      end
      if (full_set) o_full <= 1'b1;
      if (clr_rec) begin
        mode_q <= i_mode;
        o_len  <= '0;
        o_full <= 1'b0;
      end
      if (start_cap) begin
        slot_q  <= i_lrc;
        bit_cnt <= '0;
      end else if ((state_q == S_CAPTURE) && (state_d == S_CAPTURE)) begin
        shift_q <= word[DATA_W-2:0];
        bit_cnt <= bit_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_aud_recorder_multi.sv
// Bench for aud_recorder_multi: table of single-frame recordings plus directed multi-cycle sequences.
module tb_aud_recorder_multi;

  logic        i_bclk;
  logic        i_rst;
  logic        i_lrc;
  logic        i_data;
  logic [1:0]  i_mode;
  logic        i_start;
  logic        i_pause;
  logic        i_stop;

  logic [19:0] o_address, f_address;
  logic [15:0] o_data, f_data;
  logic        o_valid, f_valid;
  logic        o_busy, f_busy;
  logic        o_full, f_full;
  logic [20:0] o_len, f_len;

  aud_recorder_multi dut (
    .i_bclk(i_bclk), .i_rst(i_rst), .i_lrc(i_lrc), .i_data(i_data), .i_mode(i_mode),
    .i_start(i_start), .i_pause(i_pause), .i_stop(i_stop),
    .o_address(o_address), .o_data(o_data), .o_valid(o_valid), .o_busy(o_busy),
    .o_full(o_full), .o_len(o_len)
  );

  aud_recorder_multi #(.MAX_WORDS(5)) dut_f (
    .i_bclk(i_bclk), .i_rst(i_rst), .i_lrc(i_lrc), .i_data(i_data), .i_mode(i_mode),
    .i_start(i_start), .i_pause(i_pause), .i_stop(i_stop),
    .o_address(f_address), .o_data(f_data), .o_valid(f_valid), .o_busy(f_busy),
    .o_full(f_full), .o_len(f_len)
  );

  localparam logic [3:0] C_RST   = 4'b1000;
  localparam logic [3:0] C_START = 4'b0100;
  localparam logic [3:0] C_PAUSE = 4'b0010;
  localparam logic [3:0] C_STOP  = 4'b0001;

  typedef struct {
    logic [19:0] addr;
    logic [15:0] dat;
  } wr_t;

  typedef struct {
    logic [1:0]  mode;
    logic [15:0] l;
    logic [15:0] r;
    int          nw;
    logic [15:0] e0;
    logic [15:0] e1;
  } vec_t;

  wr_t  exp_q[$];
  wr_t  exp_f[$];
  wr_t  mon_e;
  wr_t  mon_ef;
  vec_t vecs[7];
  bit   chk_f;
  int   checks;
  int   failures;

  initial begin
    i_bclk = 1'b0;
    forever #5 i_bclk = ~i_bclk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [19:0] a, input logic [15:0] d);
    wr_t e;
    e.addr = a;
    e.dat  = d;
    exp_q.push_back(e);
  endtask

  task automatic push_f(input logic [19:0] a, input logic [15:0] d);
    wr_t e;
    e.addr = a;
    e.dat  = d;
    exp_f.push_back(e);
  endtask

  // One 32-bclk slot: edge 0 is the boundary, edges 1..16 carry MSB..LSB.
  task automatic send_slot(input logic lrc, input logic [15:0] w, input int at, input logic [3:0] c);
    for (int j = 0; j < 32; j++) begin
      @(negedge i_bclk);
      i_lrc  = lrc;
      i_data = (j >= 1 && j <= 16) ? w[16-j] : 1'b0;
      {i_rst, i_start, i_pause, i_stop} = (j == at) ? c : 4'b0000;
    end
  endtask

  task automatic send_frame(input logic [15:0] l, input logic [15:0] r);
    send_slot(1'b0, l, -1, 4'b0000);
    send_slot(1'b1, r, -1, 4'b0000);
  endtask

  task automatic pulse(input logic [3:0] c);
    @(negedge i_bclk);
    i_data = 1'b0;
    {i_rst, i_start, i_pause, i_stop} = c;
    @(negedge i_bclk);
    {i_rst, i_start, i_pause, i_stop} = 4'b0000;
  endtask

  always @(negedge i_bclk) begin
    if (o_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_write: got addr %0h data %0h expected no write", o_address, o_data);
      end else begin
        mon_e = exp_q.pop_front();
        if (o_address !== mon_e.addr || o_data !== mon_e.dat) begin
          failures++;
          $display("FAIL write: got addr %0h data %0h expected addr %0h data %0h",
                   o_address, o_data, mon_e.addr, mon_e.dat);
        end
      end
    end
    if (chk_f && f_valid) begin
      checks++;
      if (exp_f.size() == 0) begin
        failures++;
        $display("FAIL full_unexpected_write: got addr %0h data %0h expected no write", f_address, f_data);
      end else begin
        mon_ef = exp_f.pop_front();
        if (f_address !== mon_ef.addr || f_data !== mon_ef.dat) begin
          failures++;
          $display("FAIL full_write: got addr %0h data %0h expected addr %0h data %0h",
                   f_address, f_data, mon_ef.addr, mon_ef.dat);
        end
      end
    end
  end

  initial begin
    checks   = 0;
    failures = 0;
    chk_f    = 1'b0;
    vecs[0] = '{2'd0, 16'h5A5A, 16'h1111, 1, 16'h5A5A, 16'h0000};
    vecs[1] = '{2'd1, 16'h2222, 16'h1234, 1, 16'h1234, 16'h0000};
    vecs[2] = '{2'd2, 16'h0001, 16'hFFFF, 2, 16'h0001, 16'hFFFF};
    vecs[3] = '{2'd3, 16'h7FFF, 16'h7FFF, 1, 16'h7FFF, 16'h0000};
    vecs[4] = '{2'd3, 16'h8000, 16'h0001, 1, 16'hC000, 16'h0000};
    vecs[5] = '{2'd3, 16'hFFFF, 16'h0000, 1, 16'hFFFF, 16'h0000};
    vecs[6] = '{2'd3, 16'h1234, 16'hFFFF, 1, 16'h0919, 16'h0000};

    i_rst = 1'b1; i_lrc = 1'b0; i_data = 1'b0; i_mode = 2'd0;
    i_start = 1'b0; i_pause = 1'b0; i_stop = 1'b0;
    repeat (3) @(negedge i_bclk);
    chk("reset_valid", 32'(o_valid), 32'h0);
    chk("reset_busy", 32'(o_busy), 32'h0);
    chk("reset_full", 32'(o_full), 32'h0);
    chk("reset_len", 32'(o_len), 32'h0);
    chk("reset_addr", 32'(o_address), 32'h0);
    chk("reset_data", 32'(o_data), 32'h0);
    i_rst = 1'b0;
    send_slot(1'b1, 16'h0000, -1, 4'b0000);

    // Single-frame recordings, one per table row.
    for (int v = 0; v < 7; v++) begin
      i_mode = vecs[v].mode;
      push(20'd0, vecs[v].e0);
      if (vecs[v].nw == 2) push(20'd1, vecs[v].e1);
      pulse(C_START);
      chk("row_busy", 32'(o_busy), 32'h1);
      send_frame(vecs[v].l, vecs[v].r);
      pulse(C_STOP);
      chk("row_len", 32'(o_len), 32'(vecs[v].nw));
      chk("row_idle", 32'(o_busy), 32'h0);
      chk("row_drain", 32'(exp_q.size()), 32'h0);
    end

    // Right-only across two frames.
    i_mode = 2'd1;
    push(20'd0, 16'h1234);
    push(20'd1, 16'hBEEF);
    pulse(C_START);
    send_frame(16'h1111, 16'h1234);
    send_frame(16'h2222, 16'hBEEF);
    pulse(C_STOP);
    chk("right_len", 32'(o_len), 32'h2);
    chk("right_drain", 32'(exp_q.size()), 32'h0);

    // Stereo started mid-right-slot: first write is L at address 0.
    i_mode = 2'd2;
    for (int k = 0; k < 3; k++) begin
      push(20'(2*k), 16'h0001);
      push(20'(2*k+1), 16'hFFFF);
    end
    send_slot(1'b1, 16'hDEAD, 10, C_START);
    for (int k = 0; k < 3; k++) send_frame(16'h0001, 16'hFFFF);
    pulse(C_STOP);
    chk("stereo_len", 32'(o_len), 32'h6);
    chk("stereo_drain", 32'(exp_q.size()), 32'h0);

    // Full limit on the MAX_WORDS=5 instance, stereo then left-only.
    chk_f  = 1'b1;
    i_mode = 2'd2;
    for (int k = 0; k < 4; k++) begin
      push(20'(2*k), 16'h0A00 + 16'(k));
      push(20'(2*k+1), 16'h0B00 + 16'(k));
      if (k < 2) begin
        push_f(20'(2*k), 16'h0A00 + 16'(k));
        push_f(20'(2*k+1), 16'h0B00 + 16'(k));
      end
    end
    pulse(C_START);
    for (int k = 0; k < 4; k++) send_frame(16'h0A00 + 16'(k), 16'h0B00 + 16'(k));
    chk("full2_flag", 32'(f_full), 32'h1);
    chk("full2_busy", 32'(f_busy), 32'h0);
    chk("full2_len", 32'(f_len), 32'h4);
    chk("full2_main_busy", 32'(o_busy), 32'h1);
    pulse(C_STOP);
    chk("full2_main_len", 32'(o_len), 32'h8);
    i_mode = 2'd0;
    for (int k = 0; k < 6; k++) begin
      push(20'(k), 16'h0C00 + 16'(k));
      if (k < 5) push_f(20'(k), 16'h0C00 + 16'(k));
    end
    pulse(C_START);
    chk("full0_cleared", 32'(f_full), 32'h0);
    for (int k = 0; k < 4; k++) send_frame(16'h0C00 + 16'(k), 16'h0D00);
    chk("full0_not_yet", 32'(f_full), 32'h0);
    for (int k = 4; k < 6; k++) send_frame(16'h0C00 + 16'(k), 16'h0D00);
    chk("full0_flag", 32'(f_full), 32'h1);
    chk("full0_busy", 32'(f_busy), 32'h0);
    chk("full0_len", 32'(f_len), 32'h5);
    pulse(C_STOP);
    chk("full0_main_full", 32'(o_full), 32'h0);
    chk("full0_drain", 32'(exp_q.size()), 32'h0);
    chk("full0_drain_f", 32'(exp_f.size()), 32'h0);
    chk_f = 1'b0;

    // Pause after 8 bits of the third word, resume two frames later.
    i_mode = 2'd0;
    push(20'd0, 16'h1001);
    push(20'd1, 16'h1002);
    pulse(C_START);
    send_frame(16'h1001, 16'h9999);
    send_frame(16'h1002, 16'h9999);
    send_slot(1'b0, 16'h1003, 9, C_PAUSE);
    send_slot(1'b1, 16'h9999, -1, 4'b0000);
    send_frame(16'h1004, 16'h9999);
    send_frame(16'h1005, 16'h9999);
    chk("pause_busy", 32'(o_busy), 32'h1);
    chk("pause_len", 32'(o_len), 32'h2);
    push(20'd2, 16'h1006);
    pulse(C_START);
    send_frame(16'h1006, 16'h9999);
    pulse(C_STOP);
    chk("pause_final_len", 32'(o_len), 32'h3);
    chk("pause_drain", 32'(exp_q.size()), 32'h0);

    // Reset mid-capture clears everything.
    push(20'd0, 16'h4321);
    pulse(C_START);
    send_frame(16'h4321, 16'h9999);
    send_slot(1'b0, 16'h5555, 8, C_RST);
    send_slot(1'b1, 16'h9999, -1, 4'b0000);
    chk("rst_len", 32'(o_len), 32'h0);
    chk("rst_addr", 32'(o_address), 32'h0);
    chk("rst_data", 32'(o_data), 32'h0);
    chk("rst_busy", 32'(o_busy), 32'h0);
    chk("rst_valid", 32'(o_valid), 32'h0);
    chk("rst_full", 32'(o_full), 32'h0);

    // Stop on the LSB edge still emits that word.
    i_mode = 2'd0;
    push(20'd0, 16'hC0DE);
    pulse(C_START);
    send_slot(1'b0, 16'hC0DE, 16, C_STOP);
    chk("stop_busy", 32'(o_busy), 32'h0);
    send_slot(1'b1, 16'h9999, -1, 4'b0000);
    send_frame(16'h7777, 16'h8888);
    chk("stop_len", 32'(o_len), 32'h1);
    chk("stop_drain", 32'(exp_q.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/aud_recorder_multi.md
Name: aud_recorder_multi

Overview:
Parametrised I2S capture engine for the codec record path, successor to the single-channel recorder. It deserialises DATA_W-bit samples from the codec bit stream and supports left-only, right-only, interleaved stereo or mono-mix modes. It also provides pause/resume, a bounded address range with a full flag, and an explicit one-cycle write strobe toward the SRAM controller. It sits between the codec I2S pins (in the i_bclk domain) and the SRAM write port.

Parameters:
DATA_W, 16, sample width in bits (8..24); slot length must be at least DATA_W+1 bclk.
ADDR_W, 20, write address width.
MAX_WORDS, 1000000, words writable per recording (2..2^ADDR_W).

Ports:
i_bclk  in  1  codec bit clock; sole clock, all logic on its rising edge.
i_rst  in  1  synchronous reset, active-high.
i_lrc  in  1  I2S word select: 0 = left slot, 1 = right slot.
i_data  in  1  I2S serial data, MSB first.
i_mode  in  2  0 left only, 1 right only, 2 stereo interleaved, 3 mono mix; sampled only on i_start from IDLE.
i_start  in  1  level/pulse; begin new recording (IDLE) or resume (PAUSE).
i_pause  in  1  pulse; suspend recording.
i_stop  in  1  pulse; end recording.
o_address  out  ADDR_W  address of word in o_data.
o_data  out  DATA_W  captured word.
o_valid  out  1  one-cycle write strobe.
o_busy  out  1  high in any state except IDLE.
o_full  out  1  MAX_WORDS reached; held until next i_start from IDLE.
o_len  out  ADDR_W+1  words written in current/last recording.

Behaviour:
- Reset (i_rst high at an edge) gives: state IDLE; o_address, o_data, o_valid, o_busy, o_full, o_len = 0; lrc_d = 0; bit counter = 0. Reset mid-word discards the partial word, with no write.
- lrc_d holds i_lrc from the previous edge. Boundary edge = edge where i_lrc != lrc_d. The bit on the boundary edge is ignored (LSB of the prior slot). The next DATA_W edges capture MSB..LSB. Later bits in the slot are ignored.
- States: IDLE, SYNC, CAPTURE, WAIT, PAUSE.
- IDLE: on i_start, latch mode, clear o_len/write pointer/o_full, then go to SYNC.
- SYNC: wait for a boundary into the target slot, then go to CAPTURE.
  - Mode 0: target is left (i_lrc=0).
  - Mode 1: target is right (i_lrc=1).
  - Modes 2 and 3: always left, so frames start on left.
- CAPTURE: shift in DATA_W bits, then go to WAIT.
  - Mode 2: the left word is written and the machine proceeds through WAIT, capturing the right word at the next boundary.
  - Mode 3: the left word is held internally. After the right word arrives, a single write of (L+R)>>>1 is issued, computed at DATA_W+1 signed width with arithmetic shift and truncated to DATA_W.
- WAIT: idle until the next boundary needed by the mode, then go to CAPTURE.
- Write: on the edge after the LSB is captured, o_valid=1, o_data=word, o_address=write pointer; the pointer and o_len increment on that same edge. o_valid=0 on every other edge. Addresses are 0,1,2,... with no wrap. In mode 2, L lands at even addresses and R at odd.
- Full:
  - When o_len reaches MAX_WORDS after a write, go to IDLE with o_full=1.
  - Mode 2: a left capture starts only if at least 2 words remain; otherwise go to IDLE with o_full=1 immediately, so no orphan L is written.
- i_pause (CAPTURE/WAIT/SYNC): go to PAUSE, discard the partial word and the held mix-L, and keep the pointer.
- PAUSE: i_start resumes via SYNC (frame-aligned); i_stop goes to IDLE.
- i_stop (any non-IDLE state): go to IDLE, discard the partial word; o_len keeps its value.
- Priority on simultaneous inputs: i_rst > i_stop > i_pause > i_start. A write due on the same edge as i_stop or i_pause is still issued.
- o_busy is registered and reflects the state after the edge.

Test Plan:
1. Mode 1, DATA_W=16, 32-bit slots; R words 0x1234, 0xBEEF after i_start -> o_valid pulses with (addr 0, 0x1234) then (1, 0xBEEF); left data never written; o_len=2.
2. Mode 2; frame L=0x0001, R=0xFFFF, repeated 3 frames -> addresses 0..5 alternate 0x0001/0xFFFF; starting mid-right slot, the first write is L at address 0.
3. Mode 3; L=0x7FFF, R=0x7FFF -> 0x7FFF. L=0x8000, R=0x0001 -> 0xC000. L=0xFFFF, R=0x0000 -> 0xFFFF. One write per frame.
4. MAX_WORDS=5, mode 2 -> writes at addresses 0..3 only, then o_full=1, o_busy=0, o_len=4. Mode 0 -> 5 writes, o_full after the 5th.
5. i_pause asserted after 8 bits of word 2, then i_start two frames later -> partial word dropped; the next write is at address 2 with a complete, frame-aligned sample.
6. i_rst asserted mid-capture, and i_stop in the same cycle as the LSB edge -> reset clears all outputs on the next edge; stop still emits that write, then IDLE with o_len retained.
